// File: rtl/sum_sender.sv
// Frame serialiser for the beam-sum RAM: header byte, every 40-bit sum LSB first,
// then an XOR checksum of the data bytes, over a valid/ready byte stream.
module sum_sender #(
    parameter int unsigned DEPTH  = 768,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned SUM_W  = 40,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sum_read_addr,
    output logic              sum_read_en,
    input  logic [SUM_W-1:0]  sum_ram_data_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTES      = SUM_W / BYTE_W;
    localparam int unsigned CNT_W      = 3;
    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]    byte_q, byte_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [SUM_W-1:0]    shift_q, shift_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                ren_d;
    logic [BYTE_W-1:0]   data_d;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;
    logic                hs;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            entry_q       <= '0;
            byte_q        <= '0;
            csum_q        <= '0;
            shift_q       <= '0;
            sum_read_addr <= '0;
            sum_read_en   <= 1'b0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            byte_q        <= byte_d;
            csum_q        <= csum_d;
            shift_q       <= shift_d;
            sum_read_addr <= addr_d;
            sum_read_en   <= ren_d;
            tx_data       <= data_d;
            tx_valid      <= valid_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    // Next state; outputs are computed for the coming state so they register cleanly
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        byte_d  = byte_q;
        csum_d  = csum_q;
        shift_d = shift_q;
        addr_d  = sum_read_addr;
        ren_d   = 1'b0;
        data_d  = tx_data;
        valid_d = tx_valid;
        done_d  = 1'b0;
        hs      = tx_valid && tx_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HEADER;
                    entry_d = '0;
                    byte_d  = '0;
                    csum_d  = '0;
                    valid_d = 1'b1;
                    data_d  = HEADER;
                end
            end
            S_HEADER: begin
                if (hs) begin
                    state_d = S_FETCH;
                    valid_d = 1'b0;
                    ren_d   = 1'b1;
                    addr_d  = entry_q;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d = S_SEND;
                shift_d = sum_ram_data_out;
                byte_d  = '0;
                valid_d = 1'b1;
                data_d  = sum_ram_data_out[BYTE_W-1:0];
            end
            S_SEND: begin
                if (hs) begin
                    csum_d  = csum_q ^ tx_data;
                    shift_d = shift_q >> BYTE_W;
                    byte_d  = byte_q + CNT_W'(1);
                    if (byte_q == LAST_BYTE) begin
                        if (entry_q == LAST_ENTRY) begin
                            state_d = S_CHECK;
                            data_d  = csum_q ^ tx_data;
                        end else begin
                            state_d = S_FETCH;
                            entry_d = entry_q + ADDR_W'(1);
                            valid_d = 1'b0;
                            ren_d   = 1'b1;
                            addr_d  = entry_q + ADDR_W'(1);
                        end
                    end else begin
                        data_d = shift_q[2*BYTE_W-1:BYTE_W];
                    end
                end
            end
            S_CHECK: begin
                if (hs) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
